mcp_control: RTL and testbench

MCP_CONTROL -- requirements
Module: mcp_control

---
 rtl/mcp_control_if.sv | 41 ++++
 rtl/mcp_control.sv | 153 +++++++++++++++
 tb/tb_mcp_control.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mcp_control_if.sv
// Datapath-facing bundle of the multicycle controller.
// master: controller side; slave: datapath side.
interface mcp_control_if;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zf;
  logic       i_mem_ready;
  logic       o_pc_we;
  logic       o_ir_we;
  logic       o_iord;
  logic       o_mem_read;
  logic       o_mem_write;
  logic       o_reg_write;
  logic       o_reg_dst;
  logic       o_mem_to_reg;
  logic       o_ext_op;
  logic       o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [1:0] o_alu_op;
  logic [1:0] o_pc_src;
  logic [3:0] o_state;
  logic       o_illegal;

  modport master (
    input  i_opcode, i_funct, i_zf, i_mem_ready,
    output o_pc_we, o_ir_we, o_iord, o_mem_read,
    output o_mem_write, o_reg_write, o_reg_dst,
    output o_mem_to_reg, o_ext_op, o_alu_src_a,
    output o_alu_src_b, o_alu_op, o_pc_src,
    output o_state, o_illegal
  );

  modport slave (
    output i_opcode, i_funct, i_zf, i_mem_ready,
    input  o_pc_we, o_ir_we, o_iord, o_mem_read,
    input  o_mem_write, o_reg_write, o_reg_dst,
    input  o_mem_to_reg, o_ext_op, o_alu_src_a,
    input  o_alu_src_b, o_alu_op, o_pc_src,
    input  o_state, o_illegal
  );
endinterface

// File: rtl/mcp_control.sv
// Multicycle MIPS-style control FSM.
// Shared instr/data memory, trap on illegal opcode/funct.
module mcp_control (
  input  logic          i_clk,
  input  logic          i_rst,
  mcp_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    TRAP   = 4'd12
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [5:0] op_q;
  logic       funct_ok;

  // State register; opcode captured as DECODE is left
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FETCH;
      op_q  <= 6'h00;
    end else begin
      state <= nxt;
      if (state == DECODE)
        op_q <= bus.i_opcode;
    end
  end

  // Legal R-type function codes
  always_comb begin
    funct_ok = 1'b0;
    case (bus.i_funct)
      6'h20, 6'h22, 6'h24,
      6'h25, 6'h2A: funct_ok = 1'b1;
      default:      funct_ok = 1'b0;
    endcase
  end

  // Next state and per-state datapath controls
  always_comb begin
    nxt              = TRAP;
    bus.o_pc_we      = 1'b0;
    bus.o_ir_we      = 1'b0;
    bus.o_iord       = 1'b0;
    bus.o_mem_read   = 1'b0;
    bus.o_mem_write  = 1'b0;
    bus.o_reg_write  = 1'b0;
    bus.o_reg_dst    = 1'b0;
    bus.o_mem_to_reg = 1'b0;
    bus.o_ext_op     = 1'b0;
    bus.o_alu_src_a  = 1'b0;
    bus.o_alu_src_b  = 2'b00;
    bus.o_alu_op     = 2'b00;
    bus.o_pc_src     = 2'b00;
    bus.o_illegal    = 1'b0;
    case (state)
      FETCH: begin
        bus.o_mem_read  = 1'b1;
        bus.o_alu_src_b = 2'b01;
        bus.o_ir_we     = bus.i_mem_ready & ~i_rst;
        bus.o_pc_we     = bus.i_mem_ready & ~i_rst;
        nxt = bus.i_mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.o_alu_src_b = 2'b11;
        case (bus.i_opcode)
          6'h23, 6'h2B:        nxt = MEMADR;
          6'h00:               nxt = funct_ok ? EXEC : TRAP;
          6'h04, 6'h05:        nxt = BRANCH;
          6'h02:               nxt = JUMP;
          6'h08, 6'h0C, 6'h0D: nxt = IEXEC;
          default:             nxt = TRAP;
        endcase
      end
      MEMADR: begin
        bus.o_alu_src_a = 1'b1;
        bus.o_alu_src_b = 2'b10;
        bus.o_ext_op    = 1'b1;
        nxt = (op_q == 6'h2B) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.o_mem_read = 1'b1;
        bus.o_iord     = 1'b1;
        nxt = bus.i_mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.o_reg_write  = 1'b1;
        bus.o_mem_to_reg = 1'b1;
        nxt = FETCH;
      end
      MEMWR: begin
        bus.o_mem_write = 1'b1;
        bus.o_iord      = 1'b1;
        nxt = bus.i_mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        bus.o_alu_src_a = 1'b1;
        bus.o_alu_op    = 2'b10;
        nxt = ALUWB;
      end
      ALUWB: begin
        bus.o_reg_write = 1'b1;
        bus.o_reg_dst   = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        bus.o_alu_src_a = 1'b1;
        bus.o_alu_op    = 2'b01;
        bus.o_pc_src    = 2'b01;
        bus.o_pc_we     = ((op_q == 6'h04) & bus.i_zf) |
                          ((op_q == 6'h05) & ~bus.i_zf);
        nxt = FETCH;
      end
      JUMP: begin
        bus.o_pc_src = 2'b10;
        bus.o_pc_we  = 1'b1;
        nxt = FETCH;
      end
      IEXEC: begin
        bus.o_alu_src_a = 1'b1;
        bus.o_alu_src_b = 2'b10;
        bus.o_alu_op    = 2'b11;
        bus.o_ext_op    = (op_q == 6'h08);
        nxt = IWB;
      end
      IWB: begin
        bus.o_reg_write = 1'b1;
        nxt = FETCH;
      end
      TRAP: begin
        bus.o_illegal = 1'b1;
        nxt = TRAP;
      end
      default: nxt = TRAP;
    endcase
  end

  assign bus.o_state = state;

endmodule

// File: tb/tb_mcp_control.sv
// Scoreboard bench for mcp_control: stimulus pushes expected
// state/controls per cycle, a negedge monitor pops and compares.
module tb_mcp_control;

  logic clk;
  logic rst;

  mcp_control_if bus ();

  mcp_control dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ill,pc_we,ir_we,iord,mrd,mwr,rw,rdst,m2r,ext,asa,asb,aop,psrc}
  localparam logic [16:0] E_F_R  = {11'b01101000000, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] E_F_W  = {11'b00001000000, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] E_DEC  = {11'b00000000000, 2'b11, 2'b00, 2'b00};
  localparam logic [16:0] E_MADR = {11'b00000000011, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] E_MRD  = {11'b00011000000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_MWB  = {11'b00000010100, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_MWR  = {11'b00010100000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_EXEC = {11'b00000000001, 2'b00, 2'b10, 2'b00};
  localparam logic [16:0] E_AWB  = {11'b00000011000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_BR_T = {11'b01000000001, 2'b00, 2'b01, 2'b01};
  localparam logic [16:0] E_BR_N = {11'b00000000001, 2'b00, 2'b01, 2'b01};
  localparam logic [16:0] E_JMP  = {11'b01000000000, 2'b00, 2'b00, 2'b10};
  localparam logic [16:0] E_IE_S = {11'b00000000011, 2'b10, 2'b11, 2'b00};
  localparam logic [16:0] E_IE_Z = {11'b00000000001, 2'b10, 2'b11, 2'b00};
  localparam logic [16:0] E_IWB  = {11'b00000010000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_TRAP = {11'b10000000000, 2'b00, 2'b00, 2'b00};

  typedef struct {
    logic        chk;
    logic [3:0]  st;
    logic [16:0] o;
    string       nm;
  } exp_t;

  exp_t q[$];
  int checks;
  int errors;

  logic [16:0] obs;
  assign obs = {bus.o_illegal, bus.o_pc_we, bus.o_ir_we,
                bus.o_iord, bus.o_mem_read, bus.o_mem_write,
                bus.o_reg_write, bus.o_reg_dst, bus.o_mem_to_reg,
                bus.o_ext_op, bus.o_alu_src_a, bus.o_alu_src_b,
                bus.o_alu_op, bus.o_pc_src};

  // Monitor: one expected entry per cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        checks++;
        if (bus.o_state !== e.st || obs !== e.o) begin
          errors++;
          $display("FAIL %s: state=%0d ctl=%b expected state=%0d ctl=%b",
                   e.nm, bus.o_state, obs, e.st, e.o);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic [5:0] op,
                     input logic [5:0] fn, input logic z,
                     input logic mr, input logic c,
                     input logic [3:0] s, input logic [16:0] o,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.i_opcode    = op;
    bus.i_funct     = fn;
    bus.i_zf        = z;
    bus.i_mem_ready = mr;
    e.chk = c;
    e.st  = s;
    e.o   = o;
    e.nm  = nm;
    q.push_back(e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst             = 1'b1;
    bus.i_opcode    = 6'h00;
    bus.i_funct     = 6'h00;
    bus.i_zf        = 1'b0;
    bus.i_mem_ready = 1'b1;

    // reset held: FETCH, enables gated off
    cyc(1, 6'h23, 0, 0, 1, 1, 0, E_F_W, "reset_fetch");

    // lw, no waits; opcode changes after DECODE
    cyc(0, 6'h23, 0, 0, 1, 1, 0, E_F_R,  "lw_fetch");
    cyc(0, 6'h23, 0, 0, 0, 1, 1, E_DEC,  "lw_decode");
    cyc(0, 6'h2B, 0, 0, 0, 1, 2, E_MADR, "lw_memadr");
    cyc(0, 6'h2B, 0, 0, 1, 1, 3, E_MRD,  "lw_memrd");
    cyc(0, 6'h2B, 0, 0, 0, 1, 4, E_MWB,  "lw_memwb");

    // sw with fetch wait and 3 write waits
    cyc(0, 6'h2B, 0, 0, 0, 1, 0, E_F_W,  "sw_fetch_wait");
    cyc(0, 6'h2B, 0, 0, 1, 1, 0, E_F_R,  "sw_fetch");
    cyc(0, 6'h2B, 0, 0, 1, 1, 1, E_DEC,  "sw_decode");
    cyc(0, 6'h23, 0, 0, 1, 1, 2, E_MADR, "sw_memadr");
    cyc(0, 6'h23, 0, 0, 0, 1, 5, E_MWR,  "sw_wait1");
    cyc(0, 6'h23, 0, 0, 0, 1, 5, E_MWR,  "sw_wait2");
    cyc(0, 6'h23, 0, 0, 0, 1, 5, E_MWR,  "sw_wait3");
    cyc(0, 6'h23, 0, 0, 1, 1, 5, E_MWR,  "sw_done");

    // R-type add, mem_ready low outside access states
    cyc(0, 6'h00, 6'h20, 0, 1, 1, 0, E_F_R,  "add_fetch");
    cyc(0, 6'h00, 6'h20, 0, 0, 1, 1, E_DEC,  "add_decode");
    cyc(0, 6'h00, 6'h20, 0, 0, 1, 6, E_EXEC, "add_exec");
    cyc(0, 6'h00, 6'h20, 0, 0, 1, 7, E_AWB,  "add_aluwb");

    // beq taken
    cyc(0, 6'h04, 0, 1, 1, 1, 0, E_F_R,  "beq_fetch");
    cyc(0, 6'h04, 0, 1, 1, 1, 1, E_DEC,  "beq_decode");
    cyc(0, 6'h04, 0, 1, 1, 1, 8, E_BR_T, "beq_taken");

    // bne with zf=1, opcode flips to beq in BRANCH
    cyc(0, 6'h05, 0, 1, 1, 1, 0, E_F_R,  "bne_fetch");
    cyc(0, 6'h05, 0, 1, 1, 1, 1, E_DEC,  "bne_decode");
    cyc(0, 6'h04, 0, 1, 1, 1, 8, E_BR_N, "bne_not_taken");

    // jump
    cyc(0, 6'h02, 0, 0, 1, 1, 0, E_F_R, "j_fetch");
    cyc(0, 6'h02, 0, 0, 1, 1, 1, E_DEC, "j_decode");
    cyc(0, 6'h02, 0, 0, 1, 1, 9, E_JMP, "j_jump");

    // addi (sign ext), andi and ori (zero ext)
    cyc(0, 6'h08, 0, 0, 1, 1, 0,  E_F_R,  "addi_fetch");
    cyc(0, 6'h08, 0, 0, 1, 1, 1,  E_DEC,  "addi_decode");
    cyc(0, 6'h0C, 0, 0, 1, 1, 10, E_IE_S, "addi_iexec");
    cyc(0, 6'h0C, 0, 0, 1, 1, 11, E_IWB,  "addi_iwb");
    cyc(0, 6'h0C, 0, 0, 1, 1, 0,  E_F_R,  "andi_fetch");
    cyc(0, 6'h0C, 0, 0, 1, 1, 1,  E_DEC,  "andi_decode");
    cyc(0, 6'h08, 0, 0, 1, 1, 10, E_IE_Z, "andi_iexec");
    cyc(0, 6'h08, 0, 0, 1, 1, 11, E_IWB,  "andi_iwb");
    cyc(0, 6'h0D, 0, 0, 1, 1, 0,  E_F_R,  "ori_fetch");
    cyc(0, 6'h0D, 0, 0, 1, 1, 1,  E_DEC,  "ori_decode");
    cyc(0, 6'h0D, 0, 0, 1, 1, 10, E_IE_Z, "ori_iexec");
    cyc(0, 6'h0D, 0, 0, 1, 1, 11, E_IWB,  "ori_iwb");

    // illegal opcode 0x3F -> TRAP for 10 cycles
    cyc(0, 6'h3F, 0, 0, 1, 1, 0, E_F_R, "ill_fetch");
    cyc(0, 6'h3F, 0, 0, 1, 1, 1, E_DEC, "ill_decode");
    for (int i = 0; i < 10; i++)
      cyc(0, 6'h3F, 0, i[0], i[1], 1, 12, E_TRAP, "ill_trap");
    cyc(1, 6'h3F, 0, 0, 1, 0, 12, E_TRAP, "ill_rst");
    cyc(0, 6'h00, 6'h03, 0, 1, 1, 0, E_F_R, "ill_after_rst");

    // R-type bad funct 0x03 -> TRAP
    cyc(0, 6'h00, 6'h03, 0, 1, 1, 1, E_DEC, "badfn_decode");
    cyc(0, 6'h00, 6'h20, 0, 1, 1, 12, E_TRAP, "badfn_trap");
    cyc(0, 6'h00, 6'h20, 0, 1, 1, 12, E_TRAP, "badfn_hold");
    cyc(1, 6'h23, 0, 0, 1, 0, 12, E_TRAP, "badfn_rst");

    // reset while MEMRD waits
    cyc(0, 6'h23, 0, 0, 1, 1, 0, E_F_R,  "rrd_fetch");
    cyc(0, 6'h23, 0, 0, 1, 1, 1, E_DEC,  "rrd_decode");
    cyc(0, 6'h23, 0, 0, 0, 1, 2, E_MADR, "rrd_memadr");
    cyc(0, 6'h23, 0, 0, 0, 1, 3, E_MRD,  "rrd_wait");
    cyc(1, 6'h23, 0, 0, 1, 1, 3, E_MRD,  "rrd_rst");
    cyc(0, 6'h23, 0, 0, 0, 1, 0, E_F_W,  "rrd_after_rst");
    cyc(0, 6'h23, 0, 0, 1, 1, 0, E_F_R,  "rrd_fetch2");

    // drain scoreboard
    for (int i = 0; i < 5; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
